cfg_seq: RTL and testbench

Configuration sequencer between the host command interface and the PE-array controller. It buffers packed `cfg_t`-format configuration words in a FIFO and issues each one to the datapath `nt` times, overwriting the `t` field with the iteration index. It waits for datapath completion between issues, and discards idle, zero-length and illegal entries. It generalises the static configuration word into a parametrised, replaying command stream with optional sparse-mode support.

---
 rtl/cfg_seq_if.sv | 29 ++
 rtl/cfg_seq.sv | 179 +++++++++++++++++
 tb/tb_cfg_seq.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_seq_if.sv
// Handshake bundle for cfg_seq: host write channel, datapath issue channel
// and the datapath completion pulse.
//   slave  - the sequencer side
//   master - the host/datapath environment side
interface cfg_seq_if #(
    parameter int CFG_BW = 55
);
    logic [CFG_BW-1:0] cfg_in;
    logic              cfg_in_valid;
    logic              cfg_in_ready;
    logic [CFG_BW-1:0] cfg_out;
    logic              cfg_out_valid;
    logic              cfg_out_ready;
    logic              done_i;

    modport slave (
        input  cfg_in, cfg_in_valid,
        output cfg_in_ready,
        output cfg_out, cfg_out_valid,
        input  cfg_out_ready, done_i
    );

    modport master (
        output cfg_in, cfg_in_valid,
        input  cfg_in_ready,
        input  cfg_out, cfg_out_valid,
        output cfg_out_ready, done_i
    );
endinterface

// File: rtl/cfg_seq.sv
// cfg_seq: configuration sequencer in front of the PE-array controller.
// Buffers packed config words in a FIFO and replays each one nt times,
// writing the iteration index into the t field and waiting for done_i
// between issues. Idle (proc 0), zero-length (nt 0) and illegal entries
// are dropped one per cycle; illegal proc codes set the sticky err_illegal.
//
// Build option: define CFG_SEQ_SPARSE_EN to make the sparse proc codes
// 4..6 legal. Without it those codes are treated as illegal.
//
// Word layout, MSB to LSB: proc[4], nt, t, func[2], cnt0, cnt1, cnt2, n1.
module cfg_seq #(
    parameter int NUM_PE = 16,
    parameter int MAX_N  = 256,
    parameter int MAX_M  = 256,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    cfg_seq_if.slave                     bus,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         err_illegal
);

    localparam int N1_BW    = $clog2(MAX_N);
    localparam int T_BW     = $clog2(MAX_M);
    localparam int NT_BW    = $clog2(MAX_M + 1);
    localparam int CNT_BW   = $clog2((MAX_N > MAX_M) ? MAX_N : MAX_M);
    localparam int CFG_BW   = 4 + NT_BW + T_BW + 2 + 3 * CNT_BW + N1_BW;
    localparam int PTR_BW   = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int T_LSB    = N1_BW + 3 * CNT_BW + 2;
    localparam int NT_LSB   = T_LSB + T_BW;
    localparam int PROC_LSB = NT_LSB + NT_BW;

    // The FIFO pointers rely on natural wrap-around.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_PE < 1) begin : g_param_check
        $error("cfg_seq: DEPTH must be a power of two >= 2 and NUM_PE >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state;
    logic [T_BW-1:0]   iter;

    logic [CFG_BW-1:0] mem [DEPTH];
    logic [PTR_BW-1:0] wr_ptr;
    logic [PTR_BW-1:0] rd_ptr;

    logic [CFG_BW-1:0] head;
    logic [CFG_BW-1:0] head_t0;
    logic [3:0]        head_proc;
    logic [NT_BW-1:0]  head_nt;
    logic              head_legal;
    logic              head_illegal;
    logic              head_skip;
    logic              last_iter;
    logic              push;
    logic              pop;

    assign head      = mem[rd_ptr];
    assign head_proc = head[PROC_LSB +: 4];
    assign head_nt   = head[NT_LSB +: NT_BW];

    // Legal proc codes for this build; sparse modes only when enabled.
    always_comb begin
        // NOTE: assign a default before any conditional update so no path leaves the signal unassigned (which would infer a latch).
        head_legal = (head_proc >= 4'd1) && (head_proc <= 4'd3);
`ifdef CFG_SEQ_SPARSE_EN
        head_legal = head_legal || ((head_proc >= 4'd4) && (head_proc <= 4'd6));
`else
        head_legal = head_legal;
`endif
    end

    // Head word as first issued: t forced to iteration 0.
    always_comb begin
        head_t0                   = head;
        head_t0[T_LSB +: T_BW]    = '0;
    end

    assign head_illegal = !head_legal && (head_proc != 4'd0);
    assign head_skip    = !head_legal || (head_nt == '0);
    assign last_iter    = (NT_BW'(iter) + NT_BW'(1)) == head_nt;

    assign bus.cfg_in_ready = fifo_count < CNT_W'(DEPTH);
    assign busy             = (state != S_IDLE) || (fifo_count != '0);

    assign push = bus.cfg_in_valid && bus.cfg_in_ready;
    assign pop  = ((state == S_IDLE) && (fifo_count != '0) && head_skip) ||
                  ((state == S_WAIT) && bus.done_i && last_iter);

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count define which slots are valid.
        if (push) begin
            mem[wr_ptr] <= bus.cfg_in;
        end
    end

    // FIFO pointers and occupancy; rst and flush override any push or pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue FSM with registered cfg_out/cfg_out_valid; err_illegal survives flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state             <= S_IDLE;
            iter              <= '0;
            bus.cfg_out       <= '0;
            bus.cfg_out_valid <= 1'b0;
            if (rst) begin
                err_illegal <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_count != '0) begin
                        if (head_skip) begin
                            if (head_illegal) begin
                                err_illegal <= 1'b1;
                            end
                        end else begin
                            iter              <= '0;
                            bus.cfg_out       <= head_t0;
                            bus.cfg_out_valid <= 1'b1;
                            state             <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.cfg_out_ready) begin
                        bus.cfg_out_valid <= 1'b0;
                        state             <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.done_i) begin
                        if (last_iter) begin
                            state <= S_IDLE;
                        end else begin
                            iter                          <= iter + T_BW'(1);
                            bus.cfg_out[T_LSB +: T_BW]    <= iter + T_BW'(1);
                            bus.cfg_out_valid             <= 1'b1;
                            state                         <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_seq.sv
// Self-checking bench for cfg_seq. Expected issued words are queued when
// stimulus is applied; a monitor pops and compares on every issue handshake.
// Build option CFG_SEQ_SPARSE_EN changes the expectation for sparse codes.
`timescale 1ns/1ps
module tb_cfg_seq;

    localparam int CFG_BW = 55;
    localparam int DEPTH  = 8;
`ifdef CFG_SEQ_SPARSE_EN
    localparam bit SPARSE = 1'b1;
`else
    localparam bit SPARSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       busy;
    logic [3:0] fifo_count;
    logic       err_illegal;
    logic       done_auto;
    logic       done_man;
    logic       auto_done;

    int total = 0;
    int bad   = 0;
    logic [CFG_BW-1:0] exp_q[$];

    cfg_seq_if #(.CFG_BW(CFG_BW)) bus();
    assign bus.done_i = done_auto | done_man;

    cfg_seq #(
        .NUM_PE (16),
        .MAX_N  (256),
        .MAX_M  (256),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    // Layout: proc[54:51] nt[50:42] t[41:34] func[33:32] cnt0[31:24] cnt1[23:16] cnt2[15:8] n1[7:0]
    function automatic logic [CFG_BW-1:0] mk(input logic [3:0] proc, input logic [8:0] nt,
                                             input logic [7:0] t, input logic [7:0] n1);
        logic [CFG_BW-1:0] c;
        c        = '0;
        c[54:51] = proc;
        c[50:42] = nt;
        c[41:34] = t;
        c[33:32] = n1[1:0];
        c[31:24] = n1 ^ 8'h5A;
        c[23:16] = ~n1;
        c[15:8]  = n1 + 8'd3;
        c[7:0]   = n1;
        return c;
    endfunction

    function automatic logic [CFG_BW-1:0] with_t(input logic [CFG_BW-1:0] c, input logic [7:0] t);
        logic [CFG_BW-1:0] r;
        r        = c;
        r[41:34] = t;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issues(input logic [CFG_BW-1:0] c, input int nt);
        for (int i = 0; i < nt; i++) begin
            exp_q.push_back(with_t(c, 8'(i)));
        end
    endtask

    // Drive one word; returns #1 after the accepting edge.
    task automatic push_cfg(input logic [CFG_BW-1:0] c);
        int n;
        bus.cfg_in       = c;
        bus.cfg_in_valid = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.cfg_in_ready) break;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no ready required ready within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.cfg_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare every issue handshake against the queue.
    always @(negedge clk) begin
        if (!rst && bus.cfg_out_valid && bus.cfg_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue_unexpected: got 0x%0h required no issue", bus.cfg_out);
            end else begin
                check("issue", 64'(bus.cfg_out), 64'(exp_q.pop_front()));
            end
        end
    end

    // Datapath model: pulse done_i two cycles after each accepted issue.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_done && bus.cfg_out_valid && bus.cfg_out_ready) begin
                @(posedge clk);
                @(posedge clk);
                #1 done_auto = 1'b1;
                @(posedge clk);
                #1 done_auto = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish required finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CFG_BW-1:0] c;
        logic [CFG_BW-1:0] e9;
        logic [CFG_BW-1:0] e10;

        rst               = 1'b1;
        flush             = 1'b0;
        done_man          = 1'b0;
        auto_done         = 1'b0;
        bus.cfg_in        = '0;
        bus.cfg_in_valid  = 1'b0;
        bus.cfg_out_ready = 1'b0;
        repeat (3) tick();

        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_in_ready", 64'(bus.cfg_in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.cfg_out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_illegal), 64'd0);
        check("rst_cfg_out", 64'(bus.cfg_out), 64'd0);
        rst = 1'b0;
        tick();

        // Three replays of one entry; input t is ignored.
        auto_done         = 1'b1;
        bus.cfg_out_ready = 1'b1;
        c = mk(4'd1, 9'd3, 8'hAA, 8'd17);
        expect_issues(with_t(c, 8'd0), 3);
        push_cfg(c);
        check("a_count_after_push", 64'(fifo_count), 64'd1);
        check("a_valid_k1", 64'(bus.cfg_out_valid), 64'd0);
        tick();
        check("a_valid_k2", 64'(bus.cfg_out_valid), 64'd1);
        wait_drain("a", 200);
        check("a_count_end", 64'(fifo_count), 64'd0);

        // Fill to DEPTH with the datapath stalled.
        auto_done         = 1'b0;
        bus.cfg_out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            c = mk(4'd1, 9'd1, 8'd0, 8'(8'h40 + i));
            expect_issues(c, 1);
            push_cfg(c);
        end
        check("full_count", 64'(fifo_count), 64'd8);
        check("full_ready", 64'(bus.cfg_in_ready), 64'd0);
        bus.cfg_in       = mk(4'd1, 9'd1, 8'd0, 8'hEE);
        bus.cfg_in_valid = 1'b1;
        repeat (3) tick();
        bus.cfg_in_valid = 1'b0;
        check("full_ninth_rejected", 64'(fifo_count), 64'd8);
        check("full_issue_held", 64'(bus.cfg_out_valid), 64'd1);

        bus.cfg_out_ready = 1'b1;
        tick();
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        check("pop_count", 64'(fifo_count), 64'd7);
        check("pop_ready", 64'(bus.cfg_in_ready), 64'd1);
        e9 = mk(4'd2, 9'd1, 8'd0, 8'h99);
        expect_issues(e9, 1);
        bus.cfg_in       = e9;
        bus.cfg_in_valid = 1'b1;
        tick();
        bus.cfg_in_valid = 1'b0;
        check("pop_then_push_count", 64'(fifo_count), 64'd8);
        check("pop_then_push_ready", 64'(bus.cfg_in_ready), 64'd0);
        tick();
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        check("pop2_count", 64'(fifo_count), 64'd7);
        tick();
        tick();
        e10 = mk(4'd3, 9'd1, 8'd0, 8'hA0);
        expect_issues(e10, 1);
        done_man         = 1'b1;
        bus.cfg_in       = e10;
        bus.cfg_in_valid = 1'b1;
        tick();
        done_man         = 1'b0;
        bus.cfg_in_valid = 1'b0;
        check("push_pop_same_cycle", 64'(fifo_count), 64'd7);
        auto_done = 1'b1;
        wait_drain("full", 500);

        // Discards: idle, zero-length, illegal; only proc 3 issues.
        check("disc_err_before", 64'(err_illegal), 64'd0);
        push_cfg(mk(4'd0, 9'd1, 8'd0, 8'd1));
        push_cfg(mk(4'd2, 9'd0, 8'd0, 8'd2));
        push_cfg(mk(4'd9, 9'd1, 8'd0, 8'd3));
        c = mk(4'd3, 9'd1, 8'd0, 8'd33);
        expect_issues(c, 1);
        push_cfg(c);
        wait_drain("disc", 200);
        check("disc_err_after", 64'(err_illegal), 64'd1);

        // Sparse code under both builds, then boundary codes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sp_err_cleared", 64'(err_illegal), 64'd0);
        c = mk(4'd5, 9'd2, 8'd0, 8'd55);
        if (SPARSE) expect_issues(c, 2);
        push_cfg(c);
        wait_drain("sparse", 200);
        check("sparse_err", 64'(err_illegal), SPARSE ? 64'd0 : 64'd1);
        push_cfg(mk(4'd7, 9'd1, 8'd0, 8'd7));
        wait_drain("proc7", 50);
        check("proc7_err", 64'(err_illegal), 64'd1);
        c = mk(4'd1, 9'd256, 8'd0, 8'd200);
        expect_issues(c, 256);
        push_cfg(c);
        wait_drain("nt_max", 3000);

        // Flush while waiting on done_i with three entries queued.
        auto_done = 1'b0;
        push_cfg(mk(4'd15, 9'd1, 8'd0, 8'd15));
        c = mk(4'd1, 9'd2, 8'd0, 8'd70);
        expect_issues(c, 1);
        push_cfg(c);
        push_cfg(mk(4'd1, 9'd2, 8'd0, 8'd71));
        push_cfg(mk(4'd1, 9'd2, 8'd0, 8'd72));
        repeat (3) tick();
        check("fl_count_before", 64'(fifo_count), 64'd3);
        check("fl_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", 64'(fifo_count), 64'd0);
        check("fl_valid", 64'(bus.cfg_out_valid), 64'd0);
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_ready", 64'(bus.cfg_in_ready), 64'd1);
        check("fl_err_kept", 64'(err_illegal), 64'd1);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        repeat (2) tick();
        check("fl_late_done_count", 64'(fifo_count), 64'd0);
        check("fl_late_done_busy", 64'(busy), 64'd0);
        check("fl_late_done_valid", 64'(bus.cfg_out_valid), 64'd0);

        // done_i during S_ISSUE must not advance the iteration.
        bus.cfg_out_ready = 1'b0;
        c = mk(4'd1, 9'd2, 8'd0, 8'd44);
        push_cfg(c);
        repeat (3) tick();
        check("iss_valid", 64'(bus.cfg_out_valid), 64'd1);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        tick();
        check("iss_t_hold", 64'(bus.cfg_out[41:34]), 64'd0);
        check("iss_valid_hold", 64'(bus.cfg_out_valid), 64'd1);
        expect_issues(c, 2);
        auto_done         = 1'b1;
        bus.cfg_out_ready = 1'b1;
        wait_drain("iss", 200);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
